// File: rtl/neuromorphic_x1_pkg.sv
// Shared definitions for the Neuromorphic X1 Wishbone host: command modes,
// status codes, the empty-result marker, FSM states and the command-word builder.
package neuromorphic_x1_pkg;

   localparam logic [31:0] X1_ADDR_DEFAULT     = 32'h3000_000C;
   localparam int unsigned POLL_GAP_DEFAULT    = 16;
   localparam int unsigned MAX_POLLS_DEFAULT   = 255;
   localparam int unsigned ACK_TIMEOUT_DEFAULT = 1024;

   localparam logic [1:0]  MODE_PROGRAM  = 2'b11;
   localparam logic [1:0]  MODE_READ     = 2'b01;
   localparam logic [31:0] X1_EMPTY_WORD = 32'hDEAD_C0DE;

   localparam logic [1:0] STATUS_OK           = 2'b00;
   localparam logic [1:0] STATUS_POLL_TIMEOUT = 2'b01;
   localparam logic [1:0] STATUS_ACK_TIMEOUT  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_GAP  = 3'd2,
      ST_POLL = 3'd3,
      ST_RESP = 3'd4
   } host_state_e;

   // The X1 applies the >8'h7F threshold itself, so the raw value is forwarded.
   function automatic logic [31:0] build_cmd(input logic       wr,
                                             input logic [4:0] row,
                                             input logic [4:0] col,
                                             input logic [7:0] data);
      logic [31:0] word;
      if (wr) begin
         word = {MODE_PROGRAM, row, col, 12'h000, data};
      end else begin
         word = {MODE_READ, row, col, 20'h00000};
      end
      return word;
   endfunction

endpackage

// File: rtl/neuromorphic_x1_wb_host.sv
// Wishbone initiator for the Neuromorphic X1 command/result register.
// Optional ack watchdog: define NEUROMORPHIC_X1_HOST_ACK_TIMEOUT_EN.
module neuromorphic_x1_wb_host
   import neuromorphic_x1_pkg::*;
#(
   parameter logic [31:0] X1_ADDR   = X1_ADDR_DEFAULT,
   parameter int unsigned POLL_GAP  = POLL_GAP_DEFAULT,
   parameter int unsigned MAX_POLLS = MAX_POLLS_DEFAULT
`ifdef NEUROMORPHIC_X1_HOST_ACK_TIMEOUT_EN
   , parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
`endif
)(
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [4:0]  req_row,
   input  logic [4:0]  req_col,
   input  logic [7:0]  req_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_bit,
   output logic [1:0]  rsp_status,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   host_state_e state_r, state_s;
   logic        req_ready_r, rsp_valid_r, bus_cyc_r, bus_we_r;
   logic        cmd_we_r, rsp_bit_r;
   logic [1:0]  rsp_status_r;
   logic [31:0] cmd_word_r;
   logic [15:0] gap_cnt_r;
   logic [7:0]  poll_cnt_r;
   logic        accept_s, poll_inc_s, load_rsp_s, bit_s, ack_timeout_s;
   logic [1:0]  status_s;

`ifdef NEUROMORPHIC_X1_HOST_ACK_TIMEOUT_EN
   logic [15:0] wdog_r;

   // Watchdog: counts unacknowledged cycles of the current bus cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wdog_r <= 16'h0000;
      end else if (bus_cyc_r && !wbm_ack_i) begin
         wdog_r <= wdog_r + 16'h0001;
      end else begin
         wdog_r <= 16'h0000;
      end
   end

   assign ack_timeout_s = bus_cyc_r && !wbm_ack_i && (wdog_r == 16'(ACK_TIMEOUT - 1));
`else
   assign ack_timeout_s = 1'b0;
`endif

   // Next-state and response-capture decode.
   always_comb begin
      state_s    = state_r;
      accept_s   = 1'b0;
      poll_inc_s = 1'b0;
      load_rsp_s = 1'b0;
      bit_s      = 1'b0;
      status_s   = STATUS_OK;
      case (state_r)
         ST_IDLE: begin
            if (req_ready_r && req_valid) begin
               accept_s = 1'b1;
               state_s  = ST_CMD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (wbm_ack_i) begin
               if (cmd_we_r) begin
                  state_s    = ST_RESP;
                  load_rsp_s = 1'b1;
               end else begin
                  state_s = ST_GAP;
               end
            end else if (ack_timeout_s) begin
               state_s    = ST_RESP;
               load_rsp_s = 1'b1;
               status_s   = STATUS_ACK_TIMEOUT;
            end else begin
               state_s = ST_CMD;
            end
         end
         ST_GAP: begin
            state_s = (gap_cnt_r == 16'(POLL_GAP - 1)) ? ST_POLL : ST_GAP;
         end
         ST_POLL: begin
            if (wbm_ack_i) begin
               if (wbm_dat_i == X1_EMPTY_WORD) begin
                  poll_inc_s = 1'b1;
                  if (({1'b0, poll_cnt_r} + 9'd1) >= 9'(MAX_POLLS)) begin
                     state_s    = ST_RESP;
                     load_rsp_s = 1'b1;
                     status_s   = STATUS_POLL_TIMEOUT;
                  end else begin
                     state_s = ST_GAP;
                  end
               end else begin
                  state_s    = ST_RESP;
                  load_rsp_s = 1'b1;
                  bit_s      = wbm_dat_i[0];
               end
            end else if (ack_timeout_s) begin
               state_s    = ST_RESP;
               load_rsp_s = 1'b1;
               status_s   = STATUS_ACK_TIMEOUT;
            end else begin
               state_s = ST_POLL;
            end
         end
         ST_RESP: begin
            state_s = rsp_ready ? ST_IDLE : ST_RESP;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, registered handshake/bus outputs, request latch and counters.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r      <= ST_IDLE;
         req_ready_r  <= 1'b0;
         rsp_valid_r  <= 1'b0;
         bus_cyc_r    <= 1'b0;
         bus_we_r     <= 1'b0;
         cmd_we_r     <= 1'b0;
         cmd_word_r   <= 32'h0000_0000;
         gap_cnt_r    <= 16'h0000;
         poll_cnt_r   <= 8'h00;
         rsp_bit_r    <= 1'b0;
         rsp_status_r <= STATUS_OK;
      end else begin
         state_r     <= state_s;
         req_ready_r <= (state_s == ST_IDLE);
         rsp_valid_r <= (state_s == ST_RESP);
         bus_cyc_r   <= (state_s == ST_CMD) || (state_s == ST_POLL);
         bus_we_r    <= (state_s == ST_CMD);
         gap_cnt_r   <= (state_r == ST_GAP) ? (gap_cnt_r + 16'h0001) : 16'h0000;
         if (accept_s) begin
            cmd_we_r   <= req_write;
            cmd_word_r <= build_cmd(req_write, req_row, req_col, req_data);
            poll_cnt_r <= 8'h00;
         end else if (poll_inc_s) begin
            poll_cnt_r <= (poll_cnt_r == 8'hFF) ? 8'hFF : (poll_cnt_r + 8'h01);
         end else begin
            poll_cnt_r <= poll_cnt_r;
         end
         if (load_rsp_s) begin
            rsp_bit_r    <= bit_s;
            rsp_status_r <= status_s;
         end else begin
            rsp_bit_r    <= rsp_bit_r;
            rsp_status_r <= rsp_status_r;
         end
      end
   end

   assign req_ready  = req_ready_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_bit    = rsp_bit_r;
   assign rsp_status = rsp_status_r;
   assign wbm_cyc_o  = bus_cyc_r;
   assign wbm_stb_o  = bus_cyc_r;
   assign wbm_we_o   = bus_we_r;
   assign wbm_sel_o  = {4{bus_cyc_r}};
   assign wbm_adr_o  = bus_cyc_r ? X1_ADDR : 32'h0000_0000;
   assign wbm_dat_o  = bus_we_r ? cmd_word_r : 32'h0000_0000;

endmodule

// File: tb/tb_neuromorphic_x1_wb_host.sv
// Randomized self-checking bench for neuromorphic_x1_wb_host with a behavioural
// X1 slave (poll-count result delay) and a cell-level reference model.
module tb_neuromorphic_x1_wb_host;

   localparam int unsigned GAP  = 4;
   localparam int unsigned MAXP = 4;
   localparam int unsigned ATO  = 8;
   localparam logic [31:0] ADDR  = 32'h3000_000C;
   localparam logic [31:0] EMPTY = 32'hDEAD_C0DE;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
   logic [4:0]  req_row = 5'd0, req_col = 5'd0;
   logic [7:0]  req_data = 8'd0;
   logic        req_ready, rsp_valid, rsp_bit;
   logic [1:0]  rsp_status;
   logic        cyc, stb, we, ack;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o, dat_i;

   always #5 clk = ~clk;

   neuromorphic_x1_wb_host #(
      .X1_ADDR    (ADDR),
      .POLL_GAP   (GAP),
      .MAX_POLLS  (MAXP)
`ifdef NEUROMORPHIC_X1_HOST_ACK_TIMEOUT_EN
      , .ACK_TIMEOUT(ATO)
`endif
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_row   (req_row),
      .req_col   (req_col),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_bit   (rsp_bit),
      .rsp_status(rsp_status),
      .wbm_cyc_o (cyc),
      .wbm_stb_o (stb),
      .wbm_we_o  (we),
      .wbm_sel_o (sel),
      .wbm_adr_o (adr),
      .wbm_dat_o (dat_o),
      .wbm_dat_i (dat_i),
      .wbm_ack_i (ack)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // X1 slave model: cell array, one pending read result released after N empty polls.
   bit          smem [1024];
   logic        ack_r = 1'b0, late_ack = 1'b0;
   logic [31:0] sdat = 32'h0;
   int          lat = 0;
   logic        pend_valid = 1'b0, pend_bit = 1'b0;
   int          pend_left = 0;
   int          cfg_empties = 0;
   bit          cfg_noack = 1'b0;

   assign ack   = ack_r | late_ack;
   assign dat_i = sdat;

   always @(posedge clk) begin
      if (rst) begin
         ack_r <= 1'b0;
         lat   <= 0;
      end else if (ack_r) begin
         ack_r <= 1'b0;
      end else if (cyc && stb && !cfg_noack) begin
         if (lat == 0) begin
            ack_r <= 1'b1;
            lat   <= int'($urandom_range(0, 2));
            if (we) begin
               if (dat_o[31:30] == 2'b11) begin
                  smem[dat_o[29:20]] <= dat_o[7];
               end else if (dat_o[31:30] == 2'b01) begin
                  pend_valid <= 1'b1;
                  pend_bit   <= smem[dat_o[29:20]];
                  pend_left  <= cfg_empties;
               end
            end else if (pend_valid && pend_left == 0) begin
               sdat       <= {31'd0, pend_bit};
               pend_valid <= 1'b0;
            end else begin
               sdat <= EMPTY;
               if (pend_left != 0) pend_left <= pend_left - 1;
            end
         end else begin
            lat <= lat - 1;
         end
      end
   end

   // Bus monitor: cumulative totals, sampled on the falling edge.
   int          mon_polls = 0, mon_writes = 0, mon_badgap = 0, mon_badattr = 0;
   int          idle_run = 0, cyc_len = 0, last_len = 0;
   logic [31:0] last_cmd = 32'h0;
   logic        prev_cyc = 1'b0;

   always @(negedge clk) begin
      if (cyc) begin
         if (!prev_cyc) begin
            if (we) begin
               mon_writes <= mon_writes + 1;
               last_cmd   <= dat_o;
            end else begin
               mon_polls <= mon_polls + 1;
               if (idle_run != int'(GAP)) mon_badgap <= mon_badgap + 1;
            end
            if (sel !== 4'hF || adr !== ADDR || stb !== 1'b1) mon_badattr <= mon_badattr + 1;
            cyc_len <= 1;
         end else begin
            cyc_len <= cyc_len + 1;
         end
         idle_run <= 0;
      end else begin
         if (prev_cyc) last_len <= cyc_len;
         idle_run <= idle_run + 1;
      end
      prev_cyc <= cyc;
   end

   bit ref_mem [1024];

   task automatic issue(input logic w, input logic [4:0] r, input logic [4:0] c, input logic [7:0] d);
      int t;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = w;
      req_row   = r;
      req_col   = c;
      req_data  = d;
      t = 0;
      while (!req_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic do_req(input logic w, input logic [4:0] r, input logic [4:0] c, input logic [7:0] d,
                         input int empties, input int hold, input bit noack);
      int          p0, w0, g0, a0, t, exp_polls;
      logic [31:0] exp_cmd;
      logic [1:0]  exp_st;
      logic        exp_bit;
      cfg_empties = empties;
      cfg_noack   = noack;
      p0 = mon_polls; w0 = mon_writes; g0 = mon_badgap; a0 = mon_badattr;
      if (w) begin
         exp_cmd   = (32'd3 << 30) | (32'(r) << 25) | (32'(c) << 20) | 32'(d);
         exp_st    = 2'b00;
         exp_bit   = 1'b0;
         exp_polls = 0;
      end else begin
         exp_cmd = (32'd1 << 30) | (32'(r) << 25) | (32'(c) << 20);
         if (empties < int'(MAXP)) begin
            exp_st    = 2'b00;
            exp_bit   = ref_mem[{r, c}];
            exp_polls = empties + 1;
         end else begin
            exp_st    = 2'b01;
            exp_bit   = 1'b0;
            exp_polls = int'(MAXP);
         end
      end
      if (noack) begin
         exp_st    = 2'b10;
         exp_polls = 0;
      end
      issue(w, r, c, d);
      t = 0;
      while (!rsp_valid && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_status", {30'd0, rsp_status}, {30'd0, exp_st});
      if (exp_st == 2'b00) chk("rsp_bit", {31'd0, rsp_bit}, {31'd0, exp_bit});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("rsp_stall", {27'd0, rsp_valid, rsp_bit, rsp_status, req_ready, cyc},
             {27'd0, 1'b1, exp_bit, exp_st, 1'b0, 1'b0});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_release", {30'd0, rsp_valid, req_ready}, 32'd1);
      chk("cmd_word", last_cmd, exp_cmd);
      chk("cmd_count", mon_writes - w0, 32'd1);
      chk("poll_count", mon_polls - p0, exp_polls);
      chk("poll_gap", mon_badgap - g0, 32'd0);
      chk("bus_attr", mon_badattr - a0, 32'd0);
      if (noack) chk("ato_len", last_len, ATO);
      cfg_noack = 1'b0;
      if (w) ref_mem[{r, c}] = (d > 8'h7F);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic       rw;
      logic [4:0] rr, rc;
      logic [7:0] rd;
      int         t;

      repeat (3) begin
         @(negedge clk);
         chk("reset_ctl", {20'd0, req_ready, rsp_valid, rsp_bit, rsp_status, cyc, stb, we, sel}, 32'd0);
         chk("reset_bus", adr | dat_o, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

      do_req(1'b1, 5'd3, 5'd7, 8'hFF, 0, 0, 1'b0);
      do_req(1'b0, 5'd3, 5'd7, 8'h00, 3, 0, 1'b0);
      do_req(1'b0, 5'd3, 5'd7, 8'h00, 100, 0, 1'b0);
      do_req(1'b0, 5'd3, 5'd7, 8'h00, 1, 10, 1'b0);
      do_req(1'b1, 5'd0, 5'd0, 8'h7F, 0, 0, 1'b0);
      do_req(1'b0, 5'd0, 5'd0, 8'h00, 0, 0, 1'b0);

      // Late ack while idle must not disturb anything.
      @(negedge clk);
      late_ack = 1'b1;
      @(negedge clk);
      late_ack = 1'b0;
      chk("late_ack_idle", {29'd0, cyc, rsp_valid, req_ready}, 32'd1);
      @(negedge clk);
      chk("late_ack_idle2", {29'd0, cyc, rsp_valid, req_ready}, 32'd1);

      for (int i = 0; i < 40; i++) begin
         rw = 1'($urandom_range(0, 1));
         rr = 5'($urandom_range(0, 3));
         rc = 5'($urandom_range(28, 31));
         rd = 8'($urandom);
         do_req(rw, rr, rc, rd, int'($urandom_range(0, 5)), 0, 1'b0);
      end

      // Reset while polling discards the request.
      cfg_empties = 100;
      issue(1'b0, 5'd1, 5'd1, 8'h00);
      t = 0;
      while (!(cyc && !we) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("reached_poll", {30'd0, cyc, we}, 32'd2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_cyc", {30'd0, cyc, stb}, 32'd0);
      @(negedge clk);
      chk("rst_hold", {30'd0, req_ready, rsp_valid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release", {30'd0, req_ready, rsp_valid}, 32'd2);
      do_req(1'b1, 5'd9, 5'd21, 8'h80, 0, 0, 1'b0);
      do_req(1'b0, 5'd9, 5'd21, 8'h00, 2, 0, 1'b0);

`ifdef NEUROMORPHIC_X1_HOST_ACK_TIMEOUT_EN
      do_req(1'b0, 5'd5, 5'd5, 8'h00, 0, 0, 1'b1);
      @(negedge clk);
      late_ack = 1'b1;
      @(negedge clk);
      late_ack = 1'b0;
      chk("late_ack_after_abort", {29'd0, cyc, rsp_valid, req_ready}, 32'd1);
      do_req(1'b1, 5'd5, 5'd5, 8'hC0, 0, 0, 1'b0);
      do_req(1'b0, 5'd5, 5'd5, 8'h00, 1, 0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
